// File: rtl/core_config_pkg.sv
// core_config_pkg: shared core configuration for the M-extension path.
//   XLEN               datapath width
//   XLEN_INT_MIN       most negative signed XLEN value (signed-overflow dividend)
//   XLEN_ALL_ONES      all-ones XLEN value (-1 as signed)
//   div_op_t           DIV/DIVU/REM/REMU encoding as presented by issue
//   div_sched_state_t  div_sched FSM states (also exported on dbg_state)
//   op_is_signed/rem   decode helpers for div_op_t
package core_config_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] XLEN_INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] XLEN_ALL_ONES = {XLEN{1'b1}};

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    DRAIN = 3'd4
  } div_sched_state_t;

  function automatic logic op_is_signed(input div_op_t op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic op_is_rem(input div_op_t op);
    return (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin grant.
//   req_valid  per-requester request
//   ptr        requester preferred when both request
//   grant      one-hot grant (zero when nobody requests)
//   gnt_idx    index of the granted requester (0 when nobody requests)
// The pointer register lives in the parent so it only advances on a real accept.
module rr_arb2 (
  input  logic [1:0] req_valid,
  input  logic       ptr,
  output logic [1:0] grant,
  output logic       gnt_idx
);

  always_comb begin
    gnt_idx = 1'b0;
    if (req_valid == 2'b11) begin
      gnt_idx = ptr;
    end else if (req_valid[1]) begin
      gnt_idx = 1'b1;
    end
    grant = 2'b00;
    if (req_valid != 2'b00) begin
      grant = gnt_idx ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/div_sched.sv
// div_sched: shares one divider between two requesters.
//   clk, rst             clock, asynchronous active-high reset
//   flush                drop in-flight/pending work and invalidate the result cache
//   req_*                two request ports (valid/ready, op, operands, tag)
//   rsp_*                tagged result port (valid/ready)
//   div_*                drive/receive ports of the external divider
//   dbg_state            current FSM state
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both high; once raised, rsp_valid and its payload hold until that edge, and
// valid never depends combinationally on the matching ready.
// A one-entry cache keeps the last divider result so a REM following a DIV
// (or vice versa) on the same operands skips the divider entirely.
module div_sched
  import core_config_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  div_op_t [1:0]         req_op,
  input  logic [1:0][XLEN-1:0]  req_a,
  input  logic [1:0][XLEN-1:0]  req_b,
  input  logic [1:0][TAG_W-1:0] req_tag,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [TAG_W-1:0]      rsp_tag,
  output logic [XLEN-1:0]       rsp_data,
  output logic                  rsp_div_by_zero,
  output logic                  div_start,
  output logic                  div_dividend_signed,
  output logic                  div_divisor_signed,
  output logic [XLEN-1:0]       div_dividend,
  output logic [XLEN-1:0]       div_divisor,
  input  logic                  div_valid,
  input  logic [XLEN-1:0]       div_quotient,
  input  logic [XLEN-1:0]       div_remainder,
  input  logic                  div_div_by_zero,
  output div_sched_state_t      dbg_state
);

  div_sched_state_t state;
  logic             rr_ptr;
  logic [1:0]       grant;
  logic             win_id;
  logic             accept;
  div_op_t          win_op;
  logic [XLEN-1:0]  win_a;
  logic [XLEN-1:0]  win_b;
  logic             win_signed;
  logic             win_rem;
  logic             win_ovf;
  logic             win_hit;
  logic             op_rem;

  logic             cache_valid;
  logic             cache_signed;
  logic             cache_dbz;
  logic [XLEN-1:0]  cache_a;
  logic [XLEN-1:0]  cache_b;
  logic [XLEN-1:0]  cache_q;
  logic [XLEN-1:0]  cache_r;

  rr_arb2 u_arb (
    .req_valid (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .gnt_idx   (win_id)
  );

  // Reset gates ready directly so it reads 0 while rst is held, even with
  // requests pending.
  assign req_ready  = (!rst && state == IDLE && !flush) ? grant : 2'b00;
  assign accept     = |(req_valid & req_ready);

  assign win_op     = req_op[win_id];
  assign win_a      = req_a[win_id];
  assign win_b      = req_b[win_id];
  assign win_signed = op_is_signed(win_op);
  assign win_rem    = op_is_rem(win_op);
  assign win_ovf    = win_signed && (win_a == XLEN_INT_MIN) && (win_b == XLEN_ALL_ONES);
  assign win_hit    = cache_valid && (cache_a == win_a) && (cache_b == win_b) &&
                      (cache_signed == win_signed);

  assign dbg_state  = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      rr_ptr              <= 1'b0;
      op_rem              <= 1'b0;
      rsp_valid           <= 1'b0;
      rsp_id              <= 1'b0;
      rsp_tag             <= '0;
      rsp_data            <= '0;
      rsp_div_by_zero     <= 1'b0;
      div_start           <= 1'b0;
      div_dividend_signed <= 1'b0;
      div_divisor_signed  <= 1'b0;
      div_dividend        <= '0;
      div_divisor         <= '0;
      cache_valid         <= 1'b0;
      cache_signed        <= 1'b0;
      cache_dbz           <= 1'b0;
      cache_a             <= '0;
      cache_b             <= '0;
      cache_q             <= '0;
      cache_r             <= '0;
    end else begin
      div_start <= 1'b0;
      if (flush) begin
        cache_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            rr_ptr              <= ~win_id;
            rsp_id              <= win_id;
            rsp_tag             <= req_tag[win_id];
            op_rem              <= win_rem;
            div_dividend        <= win_a;
            div_divisor         <= win_b;
            div_dividend_signed <= win_signed;
            div_divisor_signed  <= win_signed;
            if (win_ovf) begin
              rsp_data        <= win_rem ? '0 : XLEN_INT_MIN;
              rsp_div_by_zero <= 1'b0;
              rsp_valid       <= 1'b1;
              state           <= RESP;
            end else if (win_hit) begin
              rsp_data        <= win_rem ? cache_r : cache_q;
              rsp_div_by_zero <= cache_dbz;
              rsp_valid       <= 1'b1;
              state           <= RESP;
            end else begin
              div_start <= 1'b1;
              state     <= START;
            end
          end
        end
        START: begin
          // The start pulse is already on the wire, so the divider runs regardless.
          state <= flush ? DRAIN : WAIT;
        end
        WAIT: begin
          if (flush) begin
            state <= div_valid ? IDLE : DRAIN;
          end else if (div_valid) begin
            cache_valid     <= 1'b1;
            cache_a         <= div_dividend;
            cache_b         <= div_divisor;
            cache_signed    <= div_dividend_signed;
            cache_q         <= div_quotient;
            cache_r         <= div_remainder;
            cache_dbz       <= div_div_by_zero;
            rsp_data        <= op_rem ? div_remainder : div_quotient;
            rsp_div_by_zero <= div_div_by_zero;
            rsp_valid       <= 1'b1;
            state           <= RESP;
          end
        end
        RESP: begin
          if (flush || rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        DRAIN: begin
          // Operands stay put: the divider may still read them until it finishes.
          if (div_valid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
